// File: rtl/square_wave_pkg.sv
// Shared types and helpers for the square-wave measurement path.
// Rounding/saturation lives here so the generator side can reuse it.
package square_wave_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} meas_state_t;

  localparam int CLK_PER_UNIT = 10;
  localparam int RW           = 16;

  typedef struct packed {
    logic          ovf;
    logic [RW-1:0] val;
  } round_t;

  // Rounds u whole units plus pre leftover cycles to the nearest unit, saturating at max_val.
  function automatic round_t round_units(input logic [RW-1:0] u,
                                         input logic [RW-1:0] pre,
                                         input logic [RW-1:0] max_val,
                                         input logic [RW-1:0] half);
    round_t     r;
    logic [RW:0] sum;
    sum = {1'b0, u} + {{RW{1'b0}}, (pre >= half)};
    if (sum > {1'b0, max_val}) begin
      r.ovf = 1'b1;
      r.val = max_val;
    end else begin
      r.ovf = 1'b0;
      r.val = sum[RW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/square_wave_meas_sync_edge_det.sv
// Two-flop synchroniser plus delay flop for an asynchronous input.
// Rise/fall are registered, so latency from pin to edge pulse is fixed at 3 edges.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, dly_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      dly_q  <= s2_q;
      rise_q <= s2_q & ~dly_q;
      fall_q <= ~s2_q & dly_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/square_wave_meas.sv
// Measures high and low time of an asynchronous square wave in units of T clk cycles.
// state | meaning
// IDLE  | waiting for a rise; partial period after reset/timeout is discarded
// HIGH  | timing the high phase
// LOW   | timing the low phase; next rise publishes the period
module square_wave_meas
  import square_wave_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4,
  parameter int T = CLK_PER_UNIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in,
  output logic [M-1:0] m_meas,
  output logic [N-1:0] n_meas,
  output logic         valid,
  output logic         ovf,
  output logic         stuck
);

  localparam int W  = ((M > N) ? M : N) + 1;
  localparam int PW = (T > 1) ? $clog2(T) : 1;
  localparam logic [RW-1:0] MAX_M = RW'((1 << M) - 1);
  localparam logic [RW-1:0] MAX_N = RW'((1 << N) - 1);
  localparam logic [RW-1:0] HALF  = RW'(T / 2);

  logic rise, fall;

  sync_edge_det u_sync (
    .clk    (clk),
    .rst_n  (rst),
    .d_i    (in),
    .rise_o (rise),
    .fall_o (fall)
  );

  meas_state_t  state_q;
  logic [PW-1:0] pre_q;
  logic [W-1:0]  u_q;
  logic [M-1:0]  hold_q, m_q;
  logic [N-1:0]  n_q;
  logic          hold_ovf_q, valid_q, ovf_q, stuck_q;
  round_t        rh, rl;
  logic          timeout;
  logic          unused_round_bits;

  always_comb begin
    rh = round_units(RW'(u_q), RW'(pre_q), MAX_M, HALF);
    rl = round_units(RW'(u_q), RW'(pre_q), MAX_N, HALF);
  end

  assign unused_round_bits = ^{rh.val[RW-1:M], rl.val[RW-1:N]};
  assign timeout = (u_q == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      u_q        <= '0;
      hold_q     <= '0;
      hold_ovf_q <= 1'b0;
      m_q        <= '0;
      n_q        <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rise || fall) stuck_q <= 1'b0;
      if (pre_q == PW'(T - 1)) begin
        pre_q <= '0;
        u_q   <= u_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      // An edge arriving in the timeout cycle takes priority over the timeout.
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= HIGH;
            pre_q   <= PW'(1);
            u_q     <= '0;
          end
        end
        HIGH: begin
          if (fall) begin
            hold_q     <= rh.val[M-1:0];
            hold_ovf_q <= rh.ovf;
            pre_q      <= PW'(1);
            u_q        <= '0;
            state_q    <= LOW;
          end else if (timeout) begin
            stuck_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        LOW: begin
          if (rise) begin
            m_q     <= hold_q;
            n_q     <= rl.val[N-1:0];
            ovf_q   <= hold_ovf_q | rl.ovf;
            valid_q <= 1'b1;
            pre_q   <= PW'(1);
            u_q     <= '0;
            state_q <= HIGH;
          end else if (timeout) begin
            stuck_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_meas = m_q;
  assign n_meas = n_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;
  assign stuck  = stuck_q;

endmodule

// File: tb/tb_square_wave_meas.sv
// Scoreboard bench for square_wave_meas: phase-length reference model feeds a queue,
// a forked monitor pops and compares on every valid.
module tb_square_wave_meas;

  localparam int T       = 10;
  localparam int MAXV    = 15;
  localparam int TIMEOUT = 310;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic [3:0] m_meas, n_meas;
  logic       valid, ovf, stuck;

  square_wave_meas #(.M(4), .N(4), .T(T)) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .m_meas (m_meas),
    .n_meas (n_meas),
    .valid  (valid),
    .ovf    (ovf),
    .stuck  (stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int n;
    int ovf;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: 0 idle, 1 timing high, 2 timing low.
  bit cur_lvl;
  int mst;
  int h_len;
  int prev_len;
  bit prev_rep;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int units(input int len);
    return (len + T / 2) / T;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic begin_phase(input bit lvl);
    exp_t e;
    if (lvl != cur_lvl) begin
      if (lvl) begin
        if (mst == 2) begin
          e.m   = sat(units(h_len));
          e.n   = sat(units(prev_len));
          e.ovf = (units(h_len) > MAXV || units(prev_len) > MAXV) ? 1 : 0;
          e.gap = prev_rep ? (h_len + prev_len) : 0;
          sb.push_back(e);
          prev_rep = 1'b1;
        end else begin
          prev_rep = 1'b0;
        end
        mst = 1;
      end else if (mst == 1) begin
        h_len = prev_len;
        mst   = 2;
      end
    end
    in      = lvl;
    cur_lvl = lvl;
  endtask

  task automatic end_phase(input int len);
    prev_len = len;
    if (mst != 0 && len > TIMEOUT) begin
      mst      = 0;
      prev_rep = 1'b0;
    end
  endtask

  task automatic phase(input bit lvl, input int len);
    begin_phase(lvl);
    repeat (len) @(negedge clk);
    end_phase(len);
  endtask

  task automatic gen(input int m, input int n, input int count);
    for (int k = 0; k < count; k++) begin
      phase(1'b1, m * T);
      phase(1'b0, n * T);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   cyc = 0;
    int   last_vcyc = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (valid === 1'b1) begin
        if (last_vcyc >= 0) chk("valid_spacing_ge2", int'((cyc - last_vcyc) >= 2), 1);
        if (sb.size() == 0) begin
          chk("unexpected_valid_queue_size", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("m_meas", int'(m_meas), e.m);
          chk("n_meas", int'(n_meas), e.n);
          chk("ovf", int'(ovf), e.ovf);
          if (e.gap > 0) chk("valid_gap", cyc - last_vcyc, e.gap);
        end
        last_vcyc = cyc;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m"}, int'(m_meas), 0);
    chk({tag, "_n"}, int'(n_meas), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_stuck"}, int'(stuck), 0);
  endtask

  initial begin
    rst      = 1'b0;
    in       = 1'b0;
    cur_lvl  = 1'b0;
    mst      = 0;
    h_len    = 0;
    prev_len = 0;
    prev_rep = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    repeat (20) @(negedge clk);

    gen(3, 5, 6);
    gen(15, 1, 4);

    phase(1'b1, 104); phase(1'b0, 95);
    phase(1'b1, 105); phase(1'b0, 94);
    phase(1'b1, 170); phase(1'b0, 20);
    phase(1'b1, 30);  phase(1'b0, 30);
    phase(1'b1, 310); phase(1'b0, 30);
    phase(1'b1, 4);   phase(1'b0, 5);
    phase(1'b1, 1);   phase(1'b0, 1);
    phase(1'b1, 1);   phase(1'b0, 1);
    phase(1'b1, 30);  phase(1'b0, 30);

    begin_phase(1'b1);
    repeat (300) @(negedge clk);
    chk("stuck_before_timeout", int'(stuck), 0);
    repeat (30) @(negedge clk);
    chk("stuck_after_timeout", int'(stuck), 1);
    repeat (70) @(negedge clk);
    end_phase(400);
    begin_phase(1'b0);
    repeat (10) @(negedge clk);
    chk("stuck_cleared_on_edge", int'(stuck), 0);
    repeat (30) @(negedge clk);
    end_phase(40);
    phase(1'b1, 30); phase(1'b0, 50);
    phase(1'b1, 20); phase(1'b0, 20);

    for (int i = 0; i < 60; i++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(300, 330))
                                        : int'($urandom_range(1, 160));
      phase(~cur_lvl, len);
    end
    if (cur_lvl) phase(1'b0, 40);
    phase(1'b1, 40); phase(1'b0, 40);

    begin_phase(1'b1);
    repeat (50) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_reset");
    in       = 1'b0;
    cur_lvl  = 1'b0;
    mst      = 0;
    prev_rep = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    phase(1'b0, 20);
    phase(1'b1, 40); phase(1'b0, 60);
    phase(1'b1, 40); phase(1'b0, 30);

    repeat (20) @(negedge clk);
    chk("pending_expected", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/square_wave_meas.md
Name: square_wave_meas

Overview:
- Measures an incoming square wave's high time and low time in 100 ns units, which is T clk cycles at 100 MHz.
- This is the receive-side counterpart of the programmable square-wave generator: feeding generator settings m, n yields m_meas = m, n_meas = n.
- Used for loopback self-test of the generator and for characterising external periodic signals.
- Results are published once per complete period with a one-cycle valid strobe.

Parameters:
- M, 4, width of m_meas (high-time result, units of T cycles).
- N, 4, width of n_meas (low-time result, units of T cycles).
- T, 10, clk cycles per measurement unit (100 ns at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous reset, active-low.
- in  input  1  square wave under measurement; asynchronous to clk.
- m_meas  output  M  last measured high time, rounded to nearest unit.
- n_meas  output  N  last measured low time, rounded to nearest unit.
- valid  output  1  one-cycle pulse; m_meas/n_meas updated this cycle.
- ovf  output  1  set with valid when either result saturated; cleared on next valid without saturation.
- stuck  output  1  level; input static beyond timeout.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst low, asserted asynchronously at any time, including mid-measurement):
  - m_meas, n_meas, valid, ovf, stuck = 0.
  - Synchroniser flops = 0; state = IDLE.
  - Deassertion is used as-is; synchronising reset release is done at top level.
- Input path:
  - Two-flop synchroniser, then a one-flop delay.
  - rise = sync & ~dly; fall = ~sync & dly.
  - Latency is constant, so measured widths equal pin widths in cycles.
- Counting:
  - Prescaler pre (0..T-1) plus unit counter u, width W = max(M,N)+1.
  - On the phase-start cycle: pre <= 1, u <= 0. That cycle counts as cycle 1 of the phase.
  - Each following cycle: pre increments; when pre == T-1 it wraps to 0 and u increments.
  - At the phase-ending edge cycle, phase length = u*T + pre cycles.
  - Rounding: result = u + (pre >= T/2), computed in W+1 bits.
  - If result exceeds the field max (2^M-1 or 2^N-1), saturate to all-ones and flag overflow for that period.
  - A phase shorter than T/2 cycles reports 0. No error is raised.
- FSM:
  - IDLE: ignore level and fall. On rise: go to HIGH, start counting. The first partial period after reset or timeout is never reported.
  - HIGH: on fall, capture rounded high result and its overflow bit into hold registers, restart counters, go to LOW.
  - LOW: on rise, drive the following on the next clk edge, then restart counters and go to HIGH:
    - m_meas <= hold;
    - n_meas <= rounded low result;
    - ovf <= hold_ovf | low_ovf;
    - valid <= 1 for one cycle.
- Timing:
  - valid rises 4 clk edges after the first edge that samples in = 1 (2 sync + 1 detect + 1 register).
  - Generator at m, n gives one valid every 10*(m+n) cycles.
- Timeout:
  - In HIGH or LOW, if u reaches 2^W-1 (310 cycles at defaults): stuck <= 1, go to IDLE, no valid.
  - stuck clears on the cycle the next rise or fall is detected.
  - m_meas/n_meas keep their last values.
- Simultaneous events: rise and fall cannot coexist, since both derive from one bit pair. A timeout and an edge in the same cycle: the edge wins.
- valid never asserts on two consecutive cycles. The minimum spacing is 2 cycles (high = low = 1 cycle).

Decomposition:
- Package square_wave_pkg holds:
  - typedef enum logic [1:0] {IDLE, HIGH, LOW} meas_state_t;
  - localparam CLK_PER_UNIT = 10, shared with the generator's T.
  - a function round_units(u, pre, max) returning a saturated value plus an overflow bit.
- Sub-module sync_edge_det: 2-flop synchroniser plus delay flop, outputs rise/fall. Reusable for other async inputs.

Test Plan:
- Generator m=3, n=5 looped to in → after the first discarded period, valid every 80 cycles with m_meas=3, n_meas=5, ovf=0, stuck=0.
- Generator m=15, n=1 → m_meas=15, n_meas=1, ovf=0; valid spacing 160 cycles.
- Hand-driven high 104 cycles / low 95 → m_meas=10, n_meas=10. Then high 105 / low 94 → m_meas=11, n_meas=9.
- High 170 cycles, low 20 → m_meas=15, n_meas=2, ovf=1. Next normal period (30/30) → m_meas=3, n_meas=3, ovf=0.
- Hold in=1 after a rise → stuck=1 at 310 cycles, no valid. Toggle in → stuck=0; first complete period afterwards reported correctly.
- Pull rst low mid-HIGH, asynchronous to clk → all outputs 0 before the next clk edge. After release, the first partial period is discarded and the second is reported correctly.
